rename_retire_queue: RTL and testbench
======================================

Name: rename_retire_queue

Overview:
In-order retirement tracker that sits on the opposite side of the register renamer. It records every renamed microop's destination and previous physical mappings, and collects out-of-order writeback completions. It retires entries strictly in program order and returns superseded physical registers to the free pool as a release mask. On flush it returns all speculatively allocated registers.

Parameters:
DEPTH, 8, number of in-flight microop entries; power of two, at least 2.
TAG_W, 3, log2(DEPTH); entry index width.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  synchronous, active-high reset.
enq_valid  input  1  renamer presents a successfully renamed microop.
enq_ready  output  1  queue can accept an entry this cycle.
enq_dst_arch  input  8  two 4-bit architectural destinations, {dst1, dst0}.
enq_dst_regs  input  2*`PR_ADDR_W  newly allocated physical regs, {p1, p0}.
enq_old_regs  input  2*`PR_ADDR_W  previous mappings, {o1, o0}.
enq_tag  output  TAG_W  index the accepted entry receives (current tail).
wb_valid  input  1  an execution unit completed an entry.
wb_tag  input  TAG_W  completed entry index.
flush  input  1  discard all in-flight entries.
retire_valid  output  1  one-cycle pulse; one entry committed.
retire_dst_arch  output  8  committed entry's architectural destinations.
retire_dst_regs  output  2*`PR_ADDR_W  committed entry's physical destinations (committed RAT update).
free_release  output  `PHYS_REGS-2  one-cycle mask of physical regs 2..`PHYS_REGS-1 returned to the pool; bit i is phys reg i+2.
count  output  TAG_W+1  occupied entries, 0..DEPTH.

Behaviour:
- Reset (synchronous, active-high): head=tail=0 and count=0. All valid and done bits are cleared. retire_valid=0, retire_dst_arch=0, retire_dst_regs=0, free_release=0, enq_tag=0. Reset overrides every other input in the same cycle.
- Each entry stores dst_arch, dst_regs, old_regs, valid and done.
- enq_ready = (count != DEPTH). It is combinational from registered count only. A retire in the same cycle does not open a slot for that cycle.
- Enqueue handshake: the entry is written at the tail on an edge where enq_valid & enq_ready. The entry gets valid=1, done=0. Tail increments modulo DEPTH. enq_tag equals tail before the increment.
- Writeback: on an edge with wb_valid, the done bit is set if entry wb_tag is valid. A writeback to an invalid entry is ignored. A repeated writeback to a done entry has no effect.
- Retire: on an edge where the head entry is valid and done (registered state), the entry is popped. The head increments modulo DEPTH and the entry's valid bit is cleared. At most one retire per cycle.
- Retire outputs are registered. They are valid during the cycle following the pop edge and return to 0 the next cycle unless another pop occurs.
- Latency: writeback accepted at edge E, head entry popped at edge E+1, retire_valid high in cycle after E+1. No writeback-to-retire bypass.
- Retire free_release sets bit (o_k - 2) for each k in {0,1} where o_k >= 2. Old regs 0 and 1 are fixed mappings and are never released.
- If o0 == o1, the bit is set once. retire_dst_arch and retire_dst_regs are copied from the entry.
- Simultaneous enqueue and retire: both happen and count is unchanged.
- Simultaneous enqueue and writeback: a writeback to the tag being enqueued in the same cycle is ignored, because that entry is not yet valid.
- Flush: on an edge with flush (and not rst), all valid and done bits are cleared and head=tail=count=0.
  - That same edge does not perform a retire, and enqueue and writeback are ignored.
  - Next cycle: retire_valid=0, and free_release = OR over all previously valid entries of bits (p_k - 2) for p_k >= 2. This returns the speculative allocations.
  - Old regs of flushed entries are not released.
- Wrap-around: head and tail wrap independently. Full versus empty is distinguished only by count.
- count = count + enq_fire - retire_fire, and is never out of range.

Test Plan:
- Reset, then enqueue entry with dst_arch=8'h32, dst_regs={5,4}, old_regs={3,2}; wb tag 0 -> retire_valid pulses 2 cycles after wb edge with free_release bits 0 and 1 set, and count returns to 0.
- Enqueue tags 0,1,2; writeback order 2,1,0 -> exactly three single-cycle retire pulses in tag order 0,1,2, no retire before tag 0 completes.
- Fill to DEPTH=8 -> enq_ready=0, an enqueue attempted while full is dropped. Retire one -> enq_ready=1 next cycle, the new entry gets tag 0 (wrap), and count never exceeds 8.
- Entry with old_regs={1,0} (arch PCH/PCL-style fixed regs) retires -> retire_valid=1 with free_release=0.
- Three entries in flight with dst_regs {6,7},{8,9},{10,0}, head done and flush asserted on the same edge -> no retire pulse. Next cycle free_release has bits 4,5,6,7,8 set, count=0 and enq_tag=0.
- rst asserted mid-operation with entries done -> all outputs 0 next cycle and no release mask emitted. Writeback to a stale tag after reset is ignored.

Source files
------------

// File: rtl/rename_retire_queue_if.sv
// rename_retire_queue_if: enqueue, writeback, flush and retire signals of the retire queue
`ifndef PR_ADDR_W
`define PR_ADDR_W 5
`endif
`ifndef PHYS_REGS
`define PHYS_REGS 32
`endif
interface rename_retire_queue_if #(parameter int TAG_W = 3);
  logic                      enq_valid;
  logic                      enq_ready;
  logic [7:0]                enq_dst_arch;
  logic [2*`PR_ADDR_W-1:0]   enq_dst_regs;
  logic [2*`PR_ADDR_W-1:0]   enq_old_regs;
  logic [TAG_W-1:0]          enq_tag;
  logic                      wb_valid;
  logic [TAG_W-1:0]          wb_tag;
  logic                      flush;
  logic                      retire_valid;
  logic [7:0]                retire_dst_arch;
  logic [2*`PR_ADDR_W-1:0]   retire_dst_regs;
  logic [`PHYS_REGS-3:0]     free_release;
  logic [TAG_W:0]            count;
  modport master (
    output enq_valid, enq_dst_arch, enq_dst_regs, enq_old_regs, wb_valid, wb_tag, flush,
    input  enq_ready, enq_tag, retire_valid, retire_dst_arch, retire_dst_regs, free_release, count
  );
  modport slave (
    input  enq_valid, enq_dst_arch, enq_dst_regs, enq_old_regs, wb_valid, wb_tag, flush,
    output enq_ready, enq_tag, retire_valid, retire_dst_arch, retire_dst_regs, free_release, count
  );
endinterface

// File: rtl/rename_retire_queue.sv
// rename_retire_queue: in-order retirement of renamed microops with physical register release
module rename_retire_queue #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 3
) (
  input logic clk,
  input logic rst,
  rename_retire_queue_if.slave q
);
  localparam int PW = `PR_ADDR_W;
  localparam int RW = `PHYS_REGS - 2;
  logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [TAG_W:0]   count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d, done_q, done_d;
  logic [7:0]       arch_q [DEPTH];
  logic [2*PW-1:0]  dst_q [DEPTH];
  logic [2*PW-1:0]  old_q [DEPTH];
  logic             rv_q, rv_d;
  logic [7:0]       rarch_q, rarch_d;
  logic [2*PW-1:0]  rdst_q, rdst_d;
  logic [RW-1:0]    rel_q, rel_d;
  logic             full, enq_fire, ret_fire;
  // Regs 0 and 1 are fixed mappings and never return to the pool
  function automatic logic [RW-1:0] rel_mask(input logic [2*PW-1:0] r);
    rel_mask = '0;
    for (int k = 0; k < 2; k++)
      if (r[k*PW +: PW] >= PW'(2)) rel_mask[r[k*PW +: PW] - PW'(2)] = 1'b1;
  endfunction
  assign full            = count_q == (TAG_W+1)'(DEPTH);
  assign enq_fire        = q.enq_valid && !full && !q.flush;
  assign ret_fire        = valid_q[head_q] && done_q[head_q];
  assign q.enq_ready       = !full;
  assign q.enq_tag         = tail_q;
  assign q.count           = count_q;
  assign q.retire_valid    = rv_q;
  assign q.retire_dst_arch = rarch_q;
  assign q.retire_dst_regs = rdst_q;
  assign q.free_release    = rel_q;
  // Next state: flush wins; otherwise writeback, then retire, then enqueue
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    done_d  = done_q;
    rv_d    = 1'b0;
    rarch_d = '0;
    rdst_d  = '0;
    rel_d   = '0;
    if (q.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      valid_d = '0;
      done_d  = '0;
      for (int i = 0; i < DEPTH; i++)
        if (valid_q[i]) rel_d |= rel_mask(dst_q[i]);
    end else begin
      if (q.wb_valid && valid_q[q.wb_tag]) done_d[q.wb_tag] = 1'b1;
      if (ret_fire) begin
        valid_d[head_q] = 1'b0;
        done_d[head_q]  = 1'b0;
        head_d          = head_q + 1'b1;
        rv_d            = 1'b1;
        rarch_d         = arch_q[head_q];
        rdst_d          = dst_q[head_q];
        rel_d           = rel_mask(old_q[head_q]);
      end
      if (enq_fire) begin
        valid_d[tail_q] = 1'b1;
        done_d[tail_q]  = 1'b0;
        tail_d          = tail_q + 1'b1;
      end
      count_d = count_q + (TAG_W+1)'(enq_fire) - (TAG_W+1)'(ret_fire);
    end
  end
  // Control and retire output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      done_q  <= '0;
      rv_q    <= 1'b0;
      rarch_q <= '0;
      rdst_q  <= '0;
      rel_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      rv_q    <= rv_d;
      rarch_q <= rarch_d;
      rdst_q  <= rdst_d;
      rel_q   <= rel_d;
    end
  end
  // Entry payload storage, written at the tail on an accepted enqueue
  always_ff @(posedge clk) begin
    if (!rst && enq_fire) begin
      arch_q[tail_q] <= q.enq_dst_arch;
      dst_q[tail_q]  <= q.enq_dst_regs;
      old_q[tail_q]  <= q.enq_old_regs;
    end
  end
endmodule

// File: tb/tb_rename_retire_queue.sv
// tb_rename_retire_queue: vector table plus scoreboarded corner sequences for the retire queue
`ifndef PR_ADDR_W
`define PR_ADDR_W 5
`endif
`ifndef PHYS_REGS
`define PHYS_REGS 32
`endif
module tb_rename_retire_queue;
  typedef struct packed {
    logic [7:0]  arch;
    logic [9:0]  regs;
    logic [29:0] rel;
  } exp_t;
  typedef struct {
    logic [7:0]  arch;
    logic [9:0]  dst;
    logic [9:0]  old;
    logic [29:0] rel;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int errors = 0;
  int pulses = 0;
  exp_t sb[$];
  exp_t e;
  vec_t tbl[6];
  always #5 clk = ~clk;
  rename_retire_queue_if #(.TAG_W(3)) bus();
  rename_retire_queue #(.DEPTH(8), .TAG_W(3)) dut (.clk(clk), .rst(rst), .q(bus));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [7:0] a, input logic [9:0] d, input logic [9:0] o,
                     input logic [29:0] rel, input logic [2:0] t);
    chk("enq_tag", 64'(bus.enq_tag), 64'(t));
    bus.enq_valid = 1'b1;
    bus.enq_dst_arch = a;
    bus.enq_dst_regs = d;
    bus.enq_old_regs = o;
    sb.push_back('{arch: a, regs: d, rel: rel});
    tick;
    bus.enq_valid = 1'b0;
  endtask

  task automatic wb(input logic [2:0] t);
    bus.wb_valid = 1'b1;
    bus.wb_tag = t;
    tick;
    bus.wb_valid = 1'b0;
  endtask

  task automatic reset_pulse;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    sb.delete();
    pulses = 0;
  endtask

  always @(posedge clk) begin
    #2;
    if (bus.retire_valid === 1'b1) begin
      pulses++;
      if (sb.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_retire: got arch %0h regs %0h, expected no retire",
                 bus.retire_dst_arch, bus.retire_dst_regs);
      end else begin
        e = sb.pop_front();
        chk("retire_data", 64'({bus.retire_dst_arch, bus.retire_dst_regs, bus.free_release}), 64'(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{8'h32, {5'd5, 5'd4},   {5'd3, 5'd2},   30'h3};
    tbl[1] = '{8'h10, {5'd9, 5'd8},   {5'd1, 5'd0},   30'h0};
    tbl[2] = '{8'h45, {5'd12, 5'd11}, {5'd7, 5'd7},   30'h20};
    tbl[3] = '{8'hff, {5'd31, 5'd30}, {5'd31, 5'd2},  30'h2000_0001};
    tbl[4] = '{8'h01, {5'd3, 5'd2},   {5'd0, 5'd6},   30'h10};
    tbl[5] = '{8'h9a, {5'd20, 5'd21}, {5'd1, 5'd17},  30'h8000};
    bus.enq_valid = 1'b0;
    bus.enq_dst_arch = '0;
    bus.enq_dst_regs = '0;
    bus.enq_old_regs = '0;
    bus.wb_valid = 1'b0;
    bus.wb_tag = '0;
    bus.flush = 1'b0;
    tick;
    tick;
    chk("rst_retire_valid", 64'(bus.retire_valid), 64'd0);
    chk("rst_free_release", 64'(bus.free_release), 64'd0);
    chk("rst_count", 64'(bus.count), 64'd0);
    chk("rst_enq_ready", 64'(bus.enq_ready), 64'd1);
    chk("rst_enq_tag", 64'(bus.enq_tag), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      enq(tbl[i].arch, tbl[i].dst, tbl[i].old, tbl[i].rel, 3'(i));
      chk("vec_count_after_enq", 64'(bus.count), 64'd1);
      wb(3'(i));
      chk("vec_no_early_retire", 64'(bus.retire_valid), 64'd0);
      tick;
      chk("vec_retire_pulse", 64'(bus.retire_valid), 64'd1);
      chk("vec_count_after_retire", 64'(bus.count), 64'd0);
      tick;
      chk("vec_retire_drop", 64'(bus.retire_valid), 64'd0);
    end

    reset_pulse;
    enq(8'h21, {5'd13, 5'd14}, {5'd4, 5'd5}, 30'hc, 3'd0);
    enq(8'h43, {5'd15, 5'd16}, {5'd1, 5'd6}, 30'h10, 3'd1);
    enq(8'h65, {5'd17, 5'd18}, {5'd9, 5'd9}, 30'h80, 3'd2);
    wb(3'd2);
    wb(3'd1);
    tick;
    tick;
    chk("ooo_no_retire_before_tag0", 64'(pulses), 64'd0);
    chk("ooo_count_held", 64'(bus.count), 64'd3);
    wb(3'd0);
    chk("ooo_wb_latency", 64'(bus.retire_valid), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("ooo_retire_pulse", 64'(bus.retire_valid), 64'd1);
    end
    tick;
    chk("ooo_retire_end", 64'(bus.retire_valid), 64'd0);
    chk("ooo_pulses", 64'(pulses), 64'd3);
    chk("ooo_count", 64'(bus.count), 64'd0);

    reset_pulse;
    for (int i = 0; i < 8; i++)
      enq(8'(i), {5'(i + 10), 5'(i + 20)}, {5'(i + 2), 5'd1}, 30'(1) << i, 3'(i));
    chk("full_count", 64'(bus.count), 64'd8);
    chk("full_not_ready", 64'(bus.enq_ready), 64'd0);
    bus.enq_valid = 1'b1;
    bus.enq_dst_arch = 8'hee;
    bus.enq_dst_regs = {5'd29, 5'd28};
    bus.enq_old_regs = {5'd27, 5'd26};
    tick;
    bus.enq_valid = 1'b0;
    chk("full_drop_count", 64'(bus.count), 64'd8);
    wb(3'd0);
    tick;
    chk("full_retire_pulse", 64'(bus.retire_valid), 64'd1);
    chk("full_ready_again", 64'(bus.enq_ready), 64'd1);
    chk("full_count_7", 64'(bus.count), 64'd7);
    enq(8'haa, {5'd3, 5'd4}, {5'd30, 5'd31}, 30'h3000_0000, 3'd0);
    chk("wrap_count", 64'(bus.count), 64'd8);
    for (int i = 1; i < 9; i++) begin
      wb(3'(i));
      chk("drain_count_bound", 64'(bus.count <= 4'd8), 64'd1);
    end
    tick;
    tick;
    chk("drain_count", 64'(bus.count), 64'd0);
    chk("drain_pulses", 64'(pulses), 64'd9);

    reset_pulse;
    enq(8'h11, {5'd6, 5'd7},  {5'd11, 5'd12}, 30'h0, 3'd0);
    enq(8'h22, {5'd8, 5'd9},  {5'd13, 5'd14}, 30'h0, 3'd1);
    enq(8'h33, {5'd10, 5'd0}, {5'd15, 5'd16}, 30'h0, 3'd2);
    wb(3'd0);
    bus.flush = 1'b1;
    tick;
    bus.flush = 1'b0;
    sb.delete();
    chk("flush_no_retire", 64'(bus.retire_valid), 64'd0);
    chk("flush_release", 64'(bus.free_release), 64'h1f0);
    chk("flush_count", 64'(bus.count), 64'd0);
    chk("flush_enq_tag", 64'(bus.enq_tag), 64'd0);
    tick;
    chk("flush_release_drop", 64'(bus.free_release), 64'd0);
    chk("flush_pulses", 64'(pulses), 64'd0);

    reset_pulse;
    enq(8'h44, {5'd20, 5'd21}, {5'd22, 5'd23}, 30'h0, 3'd0);
    enq(8'h55, {5'd24, 5'd25}, {5'd26, 5'd27}, 30'h0, 3'd1);
    wb(3'd1);
    wb(3'd0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    sb.delete();
    chk("mid_rst_retire_valid", 64'(bus.retire_valid), 64'd0);
    chk("mid_rst_release", 64'(bus.free_release), 64'd0);
    chk("mid_rst_count", 64'(bus.count), 64'd0);
    chk("mid_rst_enq_tag", 64'(bus.enq_tag), 64'd0);
    pulses = 0;
    wb(3'd0);
    wb(3'd1);
    tick;
    chk("stale_wb_count", 64'(bus.count), 64'd0);
    bus.wb_valid = 1'b1;
    bus.wb_tag = 3'd0;
    enq(8'h66, {5'd4, 5'd5}, {5'd2, 5'd3}, 30'h3, 3'd0);
    bus.wb_valid = 1'b0;
    tick;
    tick;
    tick;
    chk("same_cycle_wb_ignored_count", 64'(bus.count), 64'd1);
    chk("same_cycle_wb_no_retire", 64'(pulses), 64'd0);
    wb(3'd0);
    tick;
    chk("late_wb_retire", 64'(bus.retire_valid), 64'd1);
    tick;
    chk("late_wb_pulses", 64'(pulses), 64'd1);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
